// File: rtl/motor_pkg.sv
// Purpose: shared direction codes, BCD limits, channel state type and BCD helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package motor_pkg;

    localparam logic [1:0]  DIR_FWD  = 2'b10;
    localparam logic [1:0]  DIR_REV  = 2'b01;
    localparam logic [1:0]  DIR_STOP = 2'b00;
    localparam logic [11:0] BCD_MAX  = 12'h999;

    typedef enum logic {RUN, DEAD} chan_state_t;

    // True when all three nibbles are decimal digits.
    function automatic logic bcd_valid(input logic [11:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    // Three-digit BCD increment with per-digit ripple carry; 999 wraps to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                r[11:8] = (v[11:8] == 4'd9) ? 4'd0 : v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Purpose: command and pin bundle between motion logic and the PWM driver.
// Latency: n/a (wires only).
// Backpressure: none; commands are sampled only at PWM period boundaries.
// Ports: per-driver direction/duty commands in, IN1/IN2/PWM pins, counter and status out.
interface motor_pwm_driver_if;
    logic [1:0]  directie_driverA;
    logic [1:0]  directie_driverB;
    logic [11:0] factor_dc_driverA;
    logic [11:0] factor_dc_driverB;
    logic        in1_a;
    logic        in2_a;
    logic        pwm_a;
    logic        in1_b;
    logic        in2_b;
    logic        pwm_b;
    logic [11:0] bcd_count;
    logic        period_start;
    logic        dc_err;

    modport master (
        output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        input  in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, bcd_count, period_start, dc_err
    );

    modport slave (
        input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        output in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, bcd_count, period_start, dc_err
    );
endinterface

// File: rtl/pwm_channel.sv
// Purpose: one H-bridge channel: period-latched command, duty check, reversal dead time, pins.
// Latency: pins and pwm registered, 1 clk behind bcd_count / latched state.
// Backpressure: none; inputs between latch pulses are ignored.
// Ports: clk, rst_n, latch (wrap tick), bcd_count, dir_in, duty_in -> in1, in2, pwm, dc_err.
module pwm_channel
    import motor_pkg::*;
#(
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        latch,
    input  logic [11:0] bcd_count,
    input  logic [1:0]  dir_in,
    input  logic [11:0] duty_in,
    output logic        in1,
    output logic        in2,
    output logic        pwm,
    output logic        dc_err
);

    chan_state_t state, state_nxt;
    logic [1:0]  cur_dir, cur_dir_nxt, held_dir, held_dir_nxt;
    logic [11:0] cur_duty, cur_duty_nxt, held_duty, held_duty_nxt;
    logic [3:0]  dead_cnt, dead_cnt_nxt;
    logic        err, err_nxt;
    logic [1:0]  s_dir;
    logic [11:0] s_duty;
    logic        s_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cur_dir   <= DIR_STOP;
            cur_duty  <= 12'h000;
            held_dir  <= DIR_STOP;
            held_duty <= 12'h000;
            dead_cnt  <= 4'd0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_dir   <= cur_dir_nxt;
            cur_duty  <= cur_duty_nxt;
            held_dir  <= held_dir_nxt;
            held_duty <= held_duty_nxt;
            dead_cnt  <= dead_cnt_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_dir_nxt   = cur_dir;
        cur_duty_nxt  = cur_duty;
        held_dir_nxt  = held_dir;
        held_duty_nxt = held_duty;
        dead_cnt_nxt  = dead_cnt;
        err_nxt       = err;
        // 11 is treated as stop; an invalid duty is replaced by 000.
        s_dir  = (dir_in == 2'b11) ? DIR_STOP : dir_in;
        s_ok   = bcd_valid(duty_in);
        s_duty = s_ok ? duty_in : 12'h000;

        if (latch) begin
            err_nxt = !s_ok;
            case (state)
                RUN: begin
                    if (s_dir != DIR_STOP && cur_dir != DIR_STOP && s_dir != cur_dir) begin
                        // Reversal at speed: coast first, keep the new command pending.
                        state_nxt     = DEAD;
                        dead_cnt_nxt  = 4'(DEAD_PERIODS);
                        held_dir_nxt  = s_dir;
                        held_duty_nxt = s_duty;
                    end else begin
                        cur_dir_nxt  = s_dir;
                        cur_duty_nxt = s_duty;
                    end
                end
                DEAD: begin
                    held_dir_nxt  = s_dir;
                    held_duty_nxt = s_duty;
                    // cur_dir still holds the pre-reversal direction while dead.
                    if (s_dir == cur_dir || s_dir == DIR_STOP || dead_cnt == 4'd1) begin
                        state_nxt    = RUN;
                        dead_cnt_nxt = 4'd0;
                        cur_dir_nxt  = s_dir;
                        cur_duty_nxt = s_duty;
                    end else begin
                        dead_cnt_nxt = dead_cnt - 4'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Plain unsigned compare is exact for valid BCD, since digit order matches weight order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1 <= 1'b0;
            in2 <= 1'b0;
            pwm <= 1'b0;
        end else begin
            in1 <= (state == RUN) && (cur_dir == DIR_FWD);
            in2 <= (state == RUN) && (cur_dir == DIR_REV);
            pwm <= (state == RUN) && (cur_dir == DIR_FWD || cur_dir == DIR_REV)
                   && (bcd_count < cur_duty);
        end
    end

    assign dc_err = err;

endmodule

// File: rtl/motor_pwm_driver.sv
// Purpose: prescaled BCD period counter driving two independent L298-style PWM channels.
// Latency: pins 1 clk behind bcd_count; commands take effect at the next 999->000 wrap.
// Backpressure: none; commands are sampled only at the wrap.
// Ports: clk, rst_n, bus (slave): commands in, pins/bcd_count/period_start/dc_err out.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PRESCALE     = 50,
    parameter int DEAD_PERIODS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    motor_pwm_driver_if.slave  bus
);

    logic [15:0] presc;
    logic [11:0] bcd;
    logic        tick;
    logic        wrap;
    logic        ps_q;
    logic        err_a;
    logic        err_b;

    assign tick = (presc == 16'(PRESCALE - 1));
    assign wrap = tick && (bcd == BCD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= 16'd0;
            bcd   <= 12'h000;
            ps_q  <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick) begin
                bcd <= bcd_inc(bcd);
            end
            ps_q <= wrap;
        end
    end

    pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_chan_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .latch     (wrap),
        .bcd_count (bcd),
        .dir_in    (bus.directie_driverA),
        .duty_in   (bus.factor_dc_driverA),
        .in1       (bus.in1_a),
        .in2       (bus.in2_a),
        .pwm       (bus.pwm_a),
        .dc_err    (err_a)
    );

    pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_chan_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .latch     (wrap),
        .bcd_count (bcd),
        .dir_in    (bus.directie_driverB),
        .duty_in   (bus.factor_dc_driverB),
        .in1       (bus.in1_b),
        .in2       (bus.in2_b),
        .pwm       (bus.pwm_b),
        .dc_err    (err_b)
    );

    assign bus.bcd_count    = bcd;
    assign bus.period_start = ps_q;
    assign bus.dc_err       = err_a | err_b;

endmodule

// File: tb/tb_motor_pwm_driver.sv
module tb_motor_pwm_driver;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    motor_pwm_driver_if bus();

    motor_pwm_driver #(.PRESCALE(1), .DEAD_PERIODS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window results: cycles 1..1000 after a period_start cycle cover one whole period.
    int   w_pa, w_pb, w_ps;
    logic w_in1a, w_in2a, w_in1b, w_in2b, w_err;

    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 3000);
        checks++;
        if (bus.period_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_ps: period_start=%b after %0d cycles, required 1", bus.period_start, n);
        end
    endtask

    task automatic count_window();
        w_pa = 0; w_pb = 0; w_ps = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            w_pa += int'(bus.pwm_a);
            w_pb += int'(bus.pwm_b);
            w_ps += int'(bus.period_start);
            if (i == 500) begin
                w_in1a = bus.in1_a; w_in2a = bus.in2_a;
                w_in1b = bus.in1_b; w_in2b = bus.in2_b;
                w_err  = bus.dc_err;
            end
        end
    endtask

    task automatic set_a(input logic [1:0] d, input logic [11:0] f);
        bus.directie_driverA  = d;
        bus.factor_dc_driverA = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(2'b00, 12'h000);
        bus.directie_driverB  = 2'b00;
        bus.factor_dc_driverB = 12'h000;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in1_a, bus.in2_a, bus.pwm_a, bus.in1_b, bus.in2_b, bus.pwm_b,
             bus.period_start, bus.dc_err} !== 8'h00 || bus.bcd_count !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: pins/ps/err=%b bcd=%h, required 0 and 000",
                {bus.in1_a, bus.in2_a, bus.pwm_a, bus.in1_b, bus.in2_b, bus.pwm_b,
                 bus.period_start, bus.dc_err}, bus.bcd_count);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.bcd_count !== 12'h010) begin
            errors++;
            $display("FAIL bcd_carry_tens: bcd=%h, required 010", bus.bcd_count);
        end
        repeat (90) @(negedge clk);
        checks++;
        if (bus.bcd_count !== 12'h100 || bus.period_start !== 1'b0) begin
            errors++;
            $display("FAIL bcd_carry_hundreds: bcd=%h ps=%b, required 100 and 0",
                bus.bcd_count, bus.period_start);
        end
    endtask

    task automatic test_full_duty();
        set_a(2'b10, 12'h999);
        wait_ps();
        for (int p = 0; p < 3; p++) begin
            count_window();
            checks++;
            if (w_pa != 999 || w_ps != 1 || w_pb != 0) begin
                errors++;
                $display("FAIL full_duty[%0d]: pwm_a=%0d ps=%0d pwm_b=%0d, required 999 1 0",
                    p, w_pa, w_ps, w_pb);
            end
            checks++;
            if (w_in1a !== 1'b1 || w_in2a !== 1'b0 || w_err !== 1'b0) begin
                errors++;
                $display("FAIL full_duty_pins[%0d]: in1=%b in2=%b err=%b, required 1 0 0",
                    p, w_in1a, w_in2a, w_err);
            end
        end
    endtask

    task automatic test_dual();
        set_a(2'b10, 12'h650);
        bus.directie_driverB  = 2'b01;
        bus.factor_dc_driverB = 12'h650;
        wait_ps();
        count_window();
        checks++;
        if (w_pa != 650 || w_pb != 650) begin
            errors++;
            $display("FAIL dual_duty: pwm_a=%0d pwm_b=%0d, required 650 650", w_pa, w_pb);
        end
        checks++;
        if (w_in1b !== 1'b0 || w_in2b !== 1'b1 || w_in1a !== 1'b1) begin
            errors++;
            $display("FAIL dual_pins: in1_b=%b in2_b=%b in1_a=%b, required 0 1 1",
                w_in1b, w_in2b, w_in1a);
        end
    endtask

    task automatic test_reverse();
        repeat (300) @(negedge clk);
        set_a(2'b01, 12'h650);
        repeat (300) @(negedge clk);
        checks++;
        if (bus.in1_a !== 1'b1 || bus.in2_a !== 1'b0 || bus.pwm_a !== 1'b1) begin
            errors++;
            $display("FAIL reverse_before_wrap: in1=%b in2=%b pwm=%b, required 1 0 1",
                bus.in1_a, bus.in2_a, bus.pwm_a);
        end
        wait_ps();
        for (int p = 0; p < 2; p++) begin
            count_window();
            checks++;
            if (w_pa != 0 || w_in1a !== 1'b0 || w_in2a !== 1'b0 || w_pb != 650) begin
                errors++;
                $display("FAIL reverse_dead[%0d]: pwm_a=%0d in1=%b in2=%b pwm_b=%0d, required 0 0 0 650",
                    p, w_pa, w_in1a, w_in2a, w_pb);
            end
        end
        count_window();
        checks++;
        if (w_pa != 650 || w_in1a !== 1'b0 || w_in2a !== 1'b1) begin
            errors++;
            $display("FAIL reverse_after: pwm_a=%0d in1=%b in2=%b, required 650 0 1",
                w_pa, w_in1a, w_in2a);
        end
    endtask

    task automatic test_dc_err();
        set_a(2'b01, 12'h9A0);
        wait_ps();
        count_window();
        checks++;
        if (w_pa != 0 || w_err !== 1'b1 || w_in2a !== 1'b1) begin
            errors++;
            $display("FAIL dc_err_set: pwm_a=%0d dc_err=%b in2=%b, required 0 1 1",
                w_pa, w_err, w_in2a);
        end
        set_a(2'b01, 12'h300);
        wait_ps();
        count_window();
        checks++;
        if (w_pa != 300 || w_err !== 1'b0) begin
            errors++;
            $display("FAIL dc_err_clear: pwm_a=%0d dc_err=%b, required 300 0", w_pa, w_err);
        end
    endtask

    task automatic test_stop();
        set_a(2'b10, 12'h500);
        wait_ps();
        count_window();
        count_window();
        count_window();
        checks++;
        if (w_pa != 500 || w_in1a !== 1'b1) begin
            errors++;
            $display("FAIL stop_setup: pwm_a=%0d in1=%b, required 500 1", w_pa, w_in1a);
        end
        repeat (300) @(negedge clk);
        set_a(2'b00, 12'h500);
        repeat (300) @(negedge clk);
        checks++;
        if (bus.in1_a !== 1'b1) begin
            errors++;
            $display("FAIL stop_before_wrap: in1=%b, required 1", bus.in1_a);
        end
        wait_ps();
        count_window();
        checks++;
        if (w_pa != 0 || w_in1a !== 1'b0 || w_in2a !== 1'b0) begin
            errors++;
            $display("FAIL stop_coast: pwm_a=%0d in1=%b in2=%b, required 0 0 0",
                w_pa, w_in1a, w_in2a);
        end
        set_a(2'b01, 12'h200);
        wait_ps();
        count_window();
        checks++;
        if (w_pa != 200 || w_in2a !== 1'b1 || w_in1a !== 1'b0) begin
            errors++;
            $display("FAIL stop_to_rev: pwm_a=%0d in1=%b in2=%b, required 200 0 1",
                w_pa, w_in1a, w_in2a);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int hi;
        set_a(2'b01, 12'h800);
        wait_ps();
        wait_ps();
        repeat (400) @(negedge clk);
        checks++;
        if (bus.pwm_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: pwm_a=%b, required 1", bus.pwm_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in1_a, bus.in2_a, bus.pwm_a, bus.in1_b, bus.in2_b, bus.pwm_b} !== 6'b0 ||
            bus.bcd_count !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async: pins=%b bcd=%h, required 000000 000",
                {bus.in1_a, bus.in2_a, bus.pwm_a, bus.in1_b, bus.in2_b, bus.pwm_b}, bus.bcd_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            hi += int'(bus.pwm_a);
        end while (!bus.period_start && n < 1100);
        checks++;
        if (n != 1000 || hi != 0) begin
            errors++;
            $display("FAIL reset_mid_restart: first wrap after %0d cycles, pwm_a high %0d, required 1000 0",
                n, hi);
        end
        count_window();
        checks++;
        if (w_pa != 800 || w_in2a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_relatch: pwm_a=%0d in2=%b, required 800 1", w_pa, w_in2a);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_duty();
        test_dual();
        test_reverse();
        test_dc_err();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
